// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end.
//   instr_t     : one program entry, {op_code, ext_data}
//   seq_state_t : instr_sequencer FSM states
package cpu_pkg;

    typedef struct packed {
        logic [3:0] op_code;
        logic [7:0] ext_data;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } seq_state_t;

    localparam int unsigned INSTR_W = $bits(instr_t);

endpackage

// File: rtl/instr_mem.sv
// Program memory for instr_sequencer: DEPTH x instr_t register file.
// One synchronous write port, one asynchronous read port. Contents are not
// reset, so a loaded program survives a reset of the sequencer.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module instr_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  instr_t            wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output instr_t            rdata_o
);

    instr_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer in front of the cpu block. Replays a stored program by
// driving op_code/ext_data/ex_btn, waits SETTLE_CYCLES after each execute
// pulse, then captures the CPU result into a one-cycle result stream.
//   clk, rstn            : clock, synchronous active-low reset
//   load_en/addr/data    : program load port (honoured only in IDLE)
//   prog_len, start      : run request; length clamped to DEPTH, 0 ignored
//   abort                : stop the current run (ISSUE/WAIT/CAPTURE only)
//   op_code, ext_data    : current instruction, always mem[pc]
//   ex_btn               : one-cycle execute pulse per instruction
//   cpu_out/cf/zf        : CPU results
//   busy, done           : run status, done pulses on normal completion
//   res_valid/idx/data/cf/zf : per-instruction result stream
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = $clog2(DEPTH),
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [11:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        op_code,
    output logic [7:0]        ext_data,
    output logic              ex_btn,
    input  logic [7:0]        cpu_out,
    input  logic              cpu_cf,
    input  logic              cpu_zf,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_idx,
    output logic [7:0]        res_data,
    output logic              res_cf,
    output logic              res_zf
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    // Wait counter only needs to reach SETTLE_CYCLES-1.
    localparam int unsigned WCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] res_idx_q, res_idx_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_cf_q, res_cf_d;
    logic              res_zf_q, res_zf_d;
    logic              ex_btn_q, ex_btn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              res_valid_q, res_valid_d;

    logic              mem_we;
    logic [LEN_W-1:0]  len_clamped;
    logic              last_instr;
    instr_t            cur_instr;

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_instr_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (instr_t'(load_data)),
        .raddr_i (pc_q),
        .rdata_o (cur_instr)
    );

    assign len_clamped = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    assign last_instr  = (LEN_W'(pc_q) == (len_q - LEN_W'(1)));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        res_idx_d  = res_idx_q;
        res_data_d = res_data_q;
        res_cf_d   = res_cf_q;
        res_zf_d   = res_zf_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_we = load_en;
                if (start && (len_clamped != '0)) begin
                    pc_d    = '0;
                    len_d   = len_clamped;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_W'(SETTLE_CYCLES - 1)) begin
                    res_data_d = cpu_out;
                    res_cf_d   = cpu_cf;
                    res_zf_d   = cpu_zf;
                    res_idx_d  = pc_q;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_instr) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        ex_btn_d    = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        res_valid_d = (state_d == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            wcnt_q      <= '0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
            res_cf_q    <= 1'b0;
            res_zf_q    <= 1'b0;
            ex_btn_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            res_idx_q   <= res_idx_d;
            res_data_q  <= res_data_d;
            res_cf_q    <= res_cf_d;
            res_zf_q    <= res_zf_d;
            ex_btn_q    <= ex_btn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign op_code   = cur_instr.op_code;
    assign ext_data  = cur_instr.ext_data;
    assign ex_btn    = ex_btn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_data  = res_data_q;
    assign res_cf    = res_cf_q;
    assign res_zf    = res_zf_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. A simple cpu model returns
// ext_data+1 one cycle after ex_btn. The reference model predicts, from the
// start cycle, program length and abort cycle, when every ex_btn, result and
// done event must occur and what it must carry.
module tb_instr_sequencer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned PERIOD = SETTLE + 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [11:0]       load_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        op_code;
    logic [7:0]        ext_data;
    logic              ex_btn;
    logic [7:0]        cpu_out = '0;
    logic              cpu_cf = 1'b0;
    logic              cpu_zf = 1'b0;
    logic              busy, done, res_valid;
    logic [ADDR_W-1:0] res_idx;
    logic [7:0]        res_data;
    logic              res_cf, res_zf;

    instr_sequencer #(
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .abort     (abort),
        .op_code   (op_code),
        .ext_data  (ext_data),
        .ex_btn    (ex_btn),
        .cpu_out   (cpu_out),
        .cpu_cf    (cpu_cf),
        .cpu_zf    (cpu_zf),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_data  (res_data),
        .res_cf    (res_cf),
        .res_zf    (res_zf)
    );

    always #5 clk = ~clk;

    // cpu model: result = ext_data + 1, visible one cycle after ex_btn.
    wire [7:0] cpu_next = ext_data + 8'd1;
    always @(posedge clk) begin
        if (ex_btn) begin
            cpu_out <= cpu_next;
            cpu_cf  <= (ext_data == 8'hFF);
            cpu_zf  <= (cpu_next == 8'h00);
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  op;
        logic [7:0]  ext;
    } btn_ev_t;

    typedef struct {
        int unsigned       cyc;
        logic [ADDR_W-1:0] idx;
        logic [7:0]        data;
        logic              cf;
        logic              zf;
    } res_ev_t;

    btn_ev_t     btn_q[$];
    res_ev_t     res_q[$];
    int unsigned done_q[$];
    int unsigned busy_cnt;

    always @(negedge clk) begin
        if (rstn) begin
            if (ex_btn)    btn_q.push_back('{cyc, op_code, ext_data});
            if (res_valid) res_q.push_back('{cyc, res_idx, res_data, res_cf, res_zf});
            if (done)      done_q.push_back(cyc);
            if (busy)      busy_cnt++;
        end
    end

    logic [11:0] mem_m [DEPTH];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_entry(input logic [ADDR_W-1:0] a, input logic [11:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        mem_m[a] = d;
    endtask

    // Run one program and compare the observed event streams to the model.
    // abort_off < 0: no abort; otherwise abort is held during cycle s+abort_off.
    task automatic run_prog(input int unsigned plen, input int abort_off, input bit noise,
                            input bit load_with_start, input logic [11:0] lws_data);
        int unsigned n, s, lim, last_busy, end_cyc, exp_btn, exp_res, exp_done, exp_busy;
        logic [7:0]  r;
        n = (plen > DEPTH) ? DEPTH : plen;
        btn_q.delete(); res_q.delete(); done_q.delete(); busy_cnt = 0;
        s = cyc;
        start = 1'b1; prog_len = plen[ADDR_W:0];
        if (load_with_start) begin
            load_en = 1'b1; load_addr = '0; load_data = lws_data; mem_m[0] = lws_data;
        end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        if (abort_off >= 0) begin
            lim = s + abort_off; last_busy = lim; end_cyc = lim + 4;
        end else begin
            lim = 32'hFFFF_FFFF; last_busy = (n == 0) ? s : s + PERIOD * n + 1;
            end_cyc = s + PERIOD * n + 5;
        end
        while (cyc < end_cyc) begin
            abort = (abort_off >= 0) && (cyc == s + abort_off);
            // Loads only while the model says busy; all of them must be dropped.
            if (noise && cyc <= last_busy) begin
                load_en = 1'($urandom_range(0, 1)); load_addr = 4'($urandom);
                load_data = 12'($urandom);
            end else begin
                load_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; load_en = 1'b0;

        exp_btn = 0; exp_res = 0;
        for (int k = 0; k < int'(n); k++) begin
            if (s + 1 + PERIOD * k <= lim) exp_btn++;
            if (s + PERIOD * (k + 1) <= lim) exp_res++;
        end
        exp_done = (abort_off < 0 && n > 0) ? 1 : 0;
        exp_busy = (abort_off >= 0) ? abort_off : ((n == 0) ? 0 : PERIOD * n + 1);

        check_eq("btn_count", 32'(btn_q.size()), exp_btn);
        check_eq("res_count", 32'(res_q.size()), exp_res);
        check_eq("done_count", 32'(done_q.size()), exp_done);
        check_eq("busy_cycles", busy_cnt, exp_busy);
        check_eq("busy_after", 32'(busy), 0);
        for (int k = 0; k < int'(exp_btn) && k < btn_q.size(); k++) begin
            check_eq($sformatf("btn%0d_cyc", k), btn_q[k].cyc, s + 1 + PERIOD * k);
            check_eq($sformatf("btn%0d_instr", k), {btn_q[k].op, btn_q[k].ext}, mem_m[k]);
        end
        for (int k = 0; k < int'(exp_res) && k < res_q.size(); k++) begin
            r = mem_m[k][7:0] + 8'd1;
            check_eq($sformatf("res%0d_cyc", k), res_q[k].cyc, s + PERIOD * (k + 1));
            check_eq($sformatf("res%0d_idx", k), 32'(res_q[k].idx), k);
            check_eq($sformatf("res%0d_data", k), 32'(res_q[k].data), 32'(r));
            check_eq($sformatf("res%0d_cf", k), 32'(res_q[k].cf), 32'(mem_m[k][7:0] == 8'hFF));
            check_eq($sformatf("res%0d_zf", k), 32'(res_q[k].zf), 32'(r == 8'h00));
        end
        if (exp_done == 1 && done_q.size() > 0)
            check_eq("done_cyc", done_q[0], s + PERIOD * n + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_strobes"}, 32'({ex_btn, busy, done, res_valid}), 0);
        check_eq({tag, "_res"}, 32'({res_idx, res_data, res_cf, res_zf}), 0);
    endtask

    initial begin
        int unsigned s;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) load_entry(4'(i), 12'($urandom));
        load_entry(4'd0, 12'h105);
        load_entry(4'd1, 12'h2FF);
        check_eq("idle_instr_after_reset", 32'({op_code, ext_data}), 32'(mem_m[0]));

        // Basic two-entry run, then IDLE shows the last entry.
        run_prog(2, -1, 1'b0, 1'b0, 12'h0);
        check_eq("idle_instr_last", 32'({op_code, ext_data}), 32'(mem_m[1]));

        // Zero length is ignored; length above DEPTH is clamped.
        run_prog(0, -1, 1'b0, 1'b0, 12'h0);
        run_prog(20, -1, 1'b0, 1'b0, 12'h0);

        // Abort in WAIT of instruction 1 of a 4-entry run.
        run_prog(4, PERIOD + 2, 1'b0, 1'b0, 12'h0);

        // Load together with start, loads during the run dropped, then replay.
        run_prog(4, -1, 1'b1, 1'b1, 12'h3AA);
        run_prog(4, -1, 1'b0, 1'b0, 12'h0);

        // Reset for one cycle in WAIT of instruction 0.
        s = cyc;
        start = 1'b1; prog_len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + 3) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check_outputs_zero("midrun_reset");
        check_eq("midrun_reset_instr", 32'({op_code, ext_data}), 32'(mem_m[0]));
        @(posedge clk); #1;
        run_prog(4, -1, 1'b0, 1'b0, 12'h0);

        // Randomized runs.
        for (int it = 0; it < 10; it++) begin
            int unsigned plen, n;
            int          ab;
            for (int j = 0; j < 3; j++) load_entry(4'($urandom), 12'($urandom));
            plen = $urandom_range(0, 20);
            n = (plen > DEPTH) ? DEPTH : plen;
            ab = -1;
            if (n > 0 && $urandom_range(0, 1) == 1) ab = int'($urandom_range(1, PERIOD * n));
            run_prog(plen, ab, 1'($urandom_range(0, 1)), 1'b0, 12'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
